m2s_stream_fifo: RTL and testbench
==================================

Name: m2s_stream_fifo

Overview:
- Parametrised Avalon-MM-write to Avalon-ST-source FIFO bridge. CPU or DMA writes samples on the MM slave; the audio datapath (FIR/reverb channels) drains them on the ST source.
- Successor of the fixed 32x32 bridge. Adds configurable width and depth, first-word-fall-through source with proper valid/ready, readable fill level and status, soft flush, and a sticky underrun flag.
- Single clock domain.

Parameters:
- DATA_W, 32, data width of MM writedata/readdata and ST data.
- DEPTH, 32, total storage in words. Power of two, >= 4.
- LVL_W, 6, fill-level width, = log2(DEPTH)+1.
- AFULL_LVL, 28, almost-full threshold: status bit2 is set when level >= AFULL_LVL.

Ports:
- clock  in  1  Clock, all logic rising-edge.
- reset_n  in  1  Reset, asynchronous, active-low.
- mm_address  in  2  0=DATA (write), 1=LEVEL/CTRL, 2=STATUS.
- mm_write  in  1  MM write strobe.
- mm_writedata  in  DATA_W  MM write data.
- mm_read  in  1  MM read strobe.
- mm_readdata  out  DATA_W  MM read data, read latency 1.
- mm_waitrequest  out  1  Stalls DATA writes while full.
- st_data  out  DATA_W  Source data.
- st_valid  out  1  Source valid.
- st_ready  in  1  Sink ready, ready latency 0.
- irq  out  1  Refill request (present only with M2S_IRQ_EN).

Behaviour:
- Reset values: st_valid=0, st_data=0, mm_readdata=0, level=0, underrun=0, armed=0, irq=0.
- mm_waitrequest = !reset_n | (mm_write & mm_address==0 & full). Combinational. Reads and CTRL/STATUS writes never stall.
- Push occurs when mm_write & mm_address==0 & !full. Pop occurs when st_valid & st_ready.
- Storage is a DEPTH-1 word RAM plus one source output register. Capacity is DEPTH words. level counts both and ranges 0..DEPTH.
- Latency: a word pushed at edge N into an empty FIFO gives st_valid=1 with that word after edge N. A write in cycle N is visible on the source in cycle N+1.
- st_data is held stable while st_valid & !st_ready. st_valid is never deasserted without a pop.
- Ordering is strict FIFO. Pointers wrap modulo DEPTH-1 (RAM) with no gap or duplication.
- Simultaneous push and pop: level unchanged. When full, the push stalls (waitrequest) even if a pop occurs in the same cycle; it is accepted the next cycle.
- With level==1 and push and pop in the same cycle, the new word moves to the output register and st_valid stays 1.
- full = (level==DEPTH). empty = (level==0). afull = (level >= AFULL_LVL).
- Read of address 1 returns level, zero-extended. Address 2 returns {.., underrun[3], afull[2], full[1], empty[0]}. Address 3 reads 0.
- Write to address 1 with bit0=1 is a flush: next cycle level=0, st_valid=0, pointers reset. The flush beats a same-cycle pop, and the popped word is lost. underrun is unaffected.
- armed is set by the first push after reset or flush.
- underrun is set when armed & st_ready & !st_valid. It is sticky.
- Write of 1 to address 2 bit3 clears underrun. A same-cycle set condition wins over the clear.
- Reset asserted mid-transfer clears everything immediately (asynchronously). In-flight data is discarded.
- Writes to other addresses or bits are ignored.

Optional Feature:
- Macro: M2S_IRQ_EN.
- Defined:
  - adds the irq port and CTRL register bits [LVL_W+7:8] = low-water mark lwm (reset 0);
  - irq is registered, = armed & (level <= lwm) & irq_enable, where irq_enable is CTRL bit1 (reset 0);
  - irq updates one cycle after a level change.
  - A CTRL write also updates lwm and irq_enable. The flush bit is a self-clearing action.
- Undefined: no irq port and no lwm/irq_enable storage. CTRL bits other than bit0 are ignored.

Test Plan:
- Reset, then write 0xA5A5_0001 to addr 0 with st_ready=0 -> st_valid=1 next cycle, st_data=0xA5A5_0001, level reads 1, and data stays held for 10 cycles.
- 32 writes 0..31 with st_ready=0 -> 33rd write sees waitrequest=1, status=0x6 (full|afull), level=32. Raise st_ready -> 0..31 drain in order, one per cycle, then the stalled write completes.
- Continuous writes with st_ready toggling every cycle for 200 words -> scoreboard shows no loss or duplication across pointer wrap, and level matches the model every cycle.
- 5 words queued, st_ready=1 for 7 cycles -> 5 pops, underrun bit3 set after cycle 6. Write 0x8 to addr 2 -> bit3=0. Same-cycle clear with st_ready=1 and empty -> bit3 stays 1.
- 10 words queued, then a flush write (addr 1, 0x1) in the same cycle as a pop -> next cycle st_valid=0, level=0, and the next word written appears first.
- M2S_IRQ_EN: CTRL=0x0402 (lwm=4, en=1), 8 words, drain -> irq rises the cycle after level reaches 4. Refill to 5 -> irq falls one cycle later. Reset_n pulse mid-drain -> irq=0, st_valid=0 immediately.

Source files
------------

// File: rtl/m2s_stream_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : m2s_stream_fifo_if
// Description : MM-slave write/read bus plus ST source handshake for the
//               m2s_stream_fifo bridge. "slave" is the bridge side, "master"
//               is the CPU/DMA + sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface m2s_stream_fifo_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        mm_address;
    logic              mm_write;
    logic [DATA_W-1:0] mm_writedata;
    logic              mm_read;
    logic [DATA_W-1:0] mm_readdata;
    logic              mm_waitrequest;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;

    modport master (
        output mm_address, mm_write, mm_writedata, mm_read, st_ready,
        input  mm_readdata, mm_waitrequest, st_data, st_valid
    );

    modport slave (
        input  mm_address, mm_write, mm_writedata, mm_read, st_ready,
        output mm_readdata, mm_waitrequest, st_data, st_valid
    );
endinterface
`default_nettype wire

// File: rtl/m2s_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : m2s_stream_fifo
// Description : Avalon-MM write to Avalon-ST source FIFO bridge. DEPTH-1 word
//               RAM plus a first-word-fall-through output register, readable
//               level/status, soft flush and sticky underrun flag.
//               Optional macro M2S_IRQ_EN adds a low-water-mark refill irq.
// Revision    : 1.0 - initial release
// ============================================================================
module m2s_stream_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int LVL_W     = 6,
    parameter int AFULL_LVL = 28
) (
    input  wire              clock,
    input  wire              reset_n,
    m2s_stream_fifo_if.slave bus
`ifdef M2S_IRQ_EN
    ,
    output logic             irq
`endif
);

    // RAM holds DEPTH-1 words; index width of clog2(DEPTH) covers 0..DEPTH-2
    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 2);
    localparam logic [LVL_W-1:0] c_depth    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_afull    = LVL_W'(AFULL_LVL);

    logic [DATA_W-1:0] r_mem [0:DEPTH-2];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [DATA_W-1:0] r_st_data;
    logic              r_st_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_armed;
    logic              r_underrun;

    logic              w_full;
    logic              w_empty;
    logic              w_afull;
    logic              w_data_wr;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_ram_empty;
    logic              w_load;
    logic              w_bypass;
    logic              w_ram_wr;
    logic              w_ram_rd;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_full      = (r_level == c_depth);
    assign w_empty     = (r_level == '0);
    assign w_afull     = (r_level >= c_afull);
    assign w_data_wr   = bus.mm_write & (bus.mm_address == 2'd0);
    assign w_push      = w_data_wr & ~w_full;
    assign w_pop       = r_st_valid & bus.st_ready;
    assign w_flush     = bus.mm_write & (bus.mm_address == 2'd1) & bus.mm_writedata[0];
    // RAM is empty when the only stored word (if any) sits in the output register
    assign w_ram_empty = (r_level == {{(LVL_W-1){1'b0}}, r_st_valid});
    // Output register can take a new word this cycle
    assign w_load      = ~r_st_valid | w_pop;
    // Empty RAM: a push goes straight to the output register
    assign w_bypass    = w_load & w_ram_empty & w_push;
    assign w_ram_wr    = w_push & ~w_bypass;
    assign w_ram_rd    = w_load & ~w_ram_empty;

    assign bus.mm_waitrequest = ~reset_n | (w_data_wr & w_full);
    assign bus.st_data        = r_st_data;
    assign bus.st_valid       = r_st_valid;
    assign bus.mm_readdata    = r_rdata;

    function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage RAM write port (no reset needed, validity tracked by level)
    always_ff @(posedge clock) begin
        if (w_ram_wr) begin
            r_mem[r_wr_ptr] <= bus.mm_writedata;
        end
    end

    // Pointers, level and first-word-fall-through output register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_st_data  <= '0;
            r_st_valid <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_st_valid <= 1'b0;
        end else begin
            if (w_ram_wr) begin
                r_wr_ptr <= f_ptr_next(r_wr_ptr);
            end
            if (w_ram_rd) begin
                r_st_data  <= r_mem[r_rd_ptr];
                r_rd_ptr   <= f_ptr_next(r_rd_ptr);
                r_st_valid <= 1'b1;
            end else if (w_bypass) begin
                r_st_data  <= bus.mm_writedata;
                r_st_valid <= 1'b1;
            end else if (w_pop) begin
                r_st_valid <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Armed after the first push; sticky underrun with set winning over clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_armed    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_flush) begin
                r_armed <= 1'b0;
            end else if (w_push) begin
                r_armed <= 1'b1;
            end
            if (r_armed & bus.st_ready & ~r_st_valid) begin
                r_underrun <= 1'b1;
            end else if (bus.mm_write & (bus.mm_address == 2'd2) & bus.mm_writedata[3]) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Register-read multiplexer
    always_comb begin
        w_rd_mux = '0;
        case (bus.mm_address)
            2'd1:    w_rd_mux = {{(DATA_W-LVL_W){1'b0}}, r_level};
            2'd2:    w_rd_mux = {{(DATA_W-4){1'b0}}, r_underrun, w_afull, w_full, w_empty};
            default: w_rd_mux = '0;
        endcase
    end

    // Read data with one-cycle latency, held between reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (bus.mm_read) begin
            r_rdata <= w_rd_mux;
        end
    end

`ifdef M2S_IRQ_EN
    logic [LVL_W-1:0] r_lwm;
    logic             r_irq_en;
    logic             r_irq;

    // CTRL low-water mark / enable, and registered refill request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lwm    <= '0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (bus.mm_write & (bus.mm_address == 2'd1)) begin
                r_lwm    <= bus.mm_writedata[LVL_W+7:8];
                r_irq_en <= bus.mm_writedata[1];
            end
            r_irq <= r_armed & (r_level <= r_lwm) & r_irq_en;
        end
    end

    assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m2s_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_m2s_stream_fifo
// Description : Directed self-checking bench for m2s_stream_fifo
//               (irq section active when M2S_IRQ_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m2s_stream_fifo;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    m2s_stream_fifo_if #(.DATA_W(32)) bus ();

`ifdef M2S_IRQ_EN
    logic irq;
`endif

    m2s_stream_fifo #(
        .DATA_W    (32),
        .DEPTH     (32),
        .LVL_W     (6),
        .AFULL_LVL (28)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef M2S_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] v;
    logic [31:0] q[$];
    int          sent;
    int          mlevel;
    logic [31:0] rd_exp;
    logic        wr;
    logic        rd;
    logic        pop;
    logic        push;
    logic        done_wr;
    logic [31:0] ur_exp [0:6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        bus.mm_address   = 2'd0;
        bus.mm_write     = 1'b0;
        bus.mm_writedata = '0;
        bus.mm_read      = 1'b0;
        bus.st_ready     = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic mm_wr(input logic [1:0] addr, input logic [31:0] data);
        bus.mm_address   = addr;
        bus.mm_writedata = data;
        bus.mm_write     = 1'b1;
        tick();
        bus.mm_write     = 1'b0;
    endtask

    task automatic mm_rd(input logic [1:0] addr, output logic [31:0] data);
        bus.mm_address = addr;
        bus.mm_read    = 1'b1;
        tick();
        bus.mm_read    = 1'b0;
        data           = bus.mm_readdata;
    endtask

    initial begin
        bus_idle();
        #1;
        // ---------------- reset values ----------------
        check("rst_valid", {31'd0, bus.st_valid}, 32'd0);
        check("rst_data", bus.st_data, 32'd0);
        check("rst_rdata", bus.mm_readdata, 32'd0);
        check("rst_wait", {31'd0, bus.mm_waitrequest}, 32'd1);
        do_reset();
        mm_rd(2'd1, v); check("rst_level", v, 32'd0);
        mm_rd(2'd2, v); check("rst_status", v, 32'h1);
        mm_rd(2'd3, v); check("addr3_zero", v, 32'd0);

        // ---------------- single word, held while not ready ----------------
        mm_wr(2'd0, 32'hA5A5_0001);
        check("one_valid", {31'd0, bus.st_valid}, 32'd1);
        check("one_data", bus.st_data, 32'hA5A5_0001);
        mm_rd(2'd1, v); check("one_level", v, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_data", bus.st_data, 32'hA5A5_0001);
        end
        check("hold_valid", {31'd0, bus.st_valid}, 32'd1);
        mm_wr(2'd1, 32'h2);
        mm_rd(2'd1, v); check("noflush_level", v, 32'd1);

        // ---------------- fill to full, stall, drain ----------------
        do_reset();
        for (int i = 0; i < 32; i++) mm_wr(2'd0, i);
        mm_rd(2'd1, v); check("full_level", v, 32'd32);
        mm_rd(2'd2, v); check("full_status", v, 32'h6);
        bus.mm_address   = 2'd0;
        bus.mm_writedata = 32'd32;
        bus.mm_write     = 1'b1;
        #1;
        check("stall_wait", {31'd0, bus.mm_waitrequest}, 32'd1);
        bus.st_ready = 1'b1;
        done_wr = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            check("drain_valid", {31'd0, bus.st_valid}, 32'd1);
            check("drain_data", bus.st_data, i);
            if (bus.mm_write) begin
                check("drain_wait", {31'd0, bus.mm_waitrequest}, (i == 0) ? 32'd1 : 32'd0);
            end
            wr = bus.mm_write & ~bus.mm_waitrequest;
            tick();
            if (wr) begin
                bus.mm_write = 1'b0;
                done_wr      = 1'b1;
            end
        end
        bus.st_ready = 1'b0;
        check("drain_empty", {31'd0, bus.st_valid}, 32'd0);
        check("drain_wr_done", {31'd0, done_wr}, 32'd1);

        // ---------------- streaming with toggling ready, scoreboard ----------------
        do_reset();
        sent   = 0;
        mlevel = 0;
        q.delete();
        for (int cyc = 0; cyc < 3000 && !(sent == 200 && mlevel == 0); cyc++) begin
            rd = ((cyc % 8) == 7);
            wr = !rd && (sent < 200);
            bus.mm_read      = rd;
            bus.mm_write     = wr;
            bus.mm_address   = rd ? 2'd1 : 2'd0;
            bus.mm_writedata = 32'hC000_0000 + sent;
            bus.st_ready     = (sent < 200) ? ((cyc % 2) == 1) : 1'b1;
            #1;
            check("sb_wait", {31'd0, bus.mm_waitrequest}, {31'd0, wr && (mlevel == 32)});
            check("sb_valid", {31'd0, bus.st_valid}, {31'd0, mlevel != 0});
            pop  = bus.st_ready && (mlevel != 0);
            push = wr && (mlevel != 32);
            if (pop) begin
                check("sb_data", bus.st_data, q[0]);
                void'(q.pop_front());
            end
            if (push) begin
                q.push_back(32'hC000_0000 + sent);
                sent++;
            end
            rd_exp = mlevel;
            mlevel = mlevel + int'(push) - int'(pop);
            @(posedge clock);
            #1;
            if (rd) check("sb_level", bus.mm_readdata, rd_exp);
        end
        check("sb_done", {31'd0, (sent == 200) && (mlevel == 0)}, 32'd1);
        bus_idle();

        // ---------------- underrun set / clear ----------------
        do_reset();
        for (int i = 0; i < 5; i++) mm_wr(2'd0, 32'h50 + i);
        ur_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h9};
        bus.mm_address = 2'd2;
        bus.mm_read    = 1'b1;
        bus.st_ready   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("ur_status", bus.mm_readdata, ur_exp[k]);
        end
        bus.st_ready = 1'b0;
        bus.mm_read  = 1'b0;
        check("ur_valid", {31'd0, bus.st_valid}, 32'd0);
        mm_wr(2'd2, 32'h8);
        mm_rd(2'd2, v); check("ur_cleared", v, 32'h1);
        bus.st_ready = 1'b1;
        mm_wr(2'd2, 32'h8);
        bus.st_ready = 1'b0;
        mm_rd(2'd2, v); check("ur_set_wins", v, 32'h9);

        // ---------------- flush beats pop ----------------
        do_reset();
        for (int i = 0; i < 10; i++) mm_wr(2'd0, 32'h100 + i);
        mm_rd(2'd1, v); check("fl_pre_level", v, 32'd10);
        bus.st_ready = 1'b1;
        mm_wr(2'd1, 32'h1);
        bus.st_ready = 1'b0;
        check("fl_valid", {31'd0, bus.st_valid}, 32'd0);
        mm_rd(2'd1, v); check("fl_level", v, 32'd0);
        mm_rd(2'd2, v); check("fl_status", v, 32'h1);
        mm_wr(2'd0, 32'h0000_BEEF);
        check("fl_first_valid", {31'd0, bus.st_valid}, 32'd1);
        check("fl_first_data", bus.st_data, 32'h0000_BEEF);
        mm_wr(2'd0, 32'h0000_CAFE);
        bus.st_ready = 1'b1;
        tick();
        bus.st_ready = 1'b0;
        check("fl_second_data", bus.st_data, 32'h0000_CAFE);

`ifdef M2S_IRQ_EN
        // ---------------- low-water irq ----------------
        do_reset();
        mm_wr(2'd1, 32'h0402);
        check("irq_idle", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 8; i++) mm_wr(2'd0, 32'h200 + i);
        check("irq_filled", {31'd0, irq}, 32'd0);
        bus.st_ready = 1'b1;
        repeat (4) tick();
        bus.st_ready = 1'b0;
        check("irq_at4_lo", {31'd0, irq}, 32'd0);
        tick();
        check("irq_rise", {31'd0, irq}, 32'd1);
        mm_wr(2'd0, 32'h300);
        check("irq_refill_hold", {31'd0, irq}, 32'd1);
        tick();
        check("irq_fall", {31'd0, irq}, 32'd0);
        bus.st_ready = 1'b1;
        repeat (2) tick();
        check("irq_redrain", {31'd0, irq}, 32'd1);
        check("irq_mid_valid", {31'd0, bus.st_valid}, 32'd1);
        reset_n = 1'b0;
        #2;
        check("irq_async_rst", {31'd0, irq}, 32'd0);
        check("valid_async_rst", {31'd0, bus.st_valid}, 32'd0);
        tick();
        bus_idle();
        reset_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
